// File: rtl/beat_packer_pkg.sv
// Shared types and helpers for the beat packer controller.
// Optional flush support is enabled by defining BEAT_PACKER_FLUSH_EN.
package beat_packer_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    PAD  = 2'd2
  } state_e;

  // Width needed to count 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/beat_packer_ctrl_shift.sv
// beat_shift_register: DEPTH x WIDTH shift register, newest beat in the low slice.
module beat_shift_register #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   write_en,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH*DEPTH-1:0] data_out
);

  localparam int unsigned TOTAL_W = WIDTH * DEPTH;

  logic [TOTAL_W-1:0] data_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else if (write_en) begin
          data_q <= data_in;
        end
      end
    end else begin : g_multi
      // Older beats move up one slice; the new beat lands at the bottom.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else if (write_en) begin
          data_q <= {data_q[TOTAL_W-WIDTH-1:0], data_in};
        end
      end
    end
  endgenerate

  assign data_out = data_q;

endmodule

// File: rtl/beat_packer_ctrl.sv
// Packs DEPTH narrow beats into one wide word using beat_shift_register.
// Define BEAT_PACKER_FLUSH_EN to add in_last and zero-padding of short words.
module beat_packer_ctrl
  import beat_packer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
`ifdef BEAT_PACKER_FLUSH_EN
  input  logic                                in_last,
`endif
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH*DEPTH-1:0]              out_data,
  output logic [cnt_width(DEPTH)-1:0]         beat_cnt
);

  localparam int unsigned CW = cnt_width(DEPTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc_c;
  logic            write_en_c;
  logic [WIDTH-1:0] shift_in_c;
  logic            last_c;

`ifdef BEAT_PACKER_FLUSH_EN
  assign last_c = in_last;
`else
  assign last_c = 1'b0;
`endif

  assign cnt_inc_c = cnt_q + CW'(1);

  // State and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, handshake and register control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    write_en_c = 1'b0;
    shift_in_c = in_data;

    case (state_q)
      FILL: begin
        // Held low while reset is asserted, since state_q already reads FILL.
        in_ready   = ~rst;
        write_en_c = in_valid & ~rst;
        if (in_valid && !rst) begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CW'(DEPTH)) begin
            state_d = HOLD;
          end else if (last_c) begin
            state_d = PAD;
          end
        end
      end

      HOLD: begin
        // Bypass: a beat may enter in the same cycle the word leaves.
        in_ready   = out_ready;
        write_en_c = out_ready & in_valid;
        if (out_ready) begin
          if (in_valid) begin
            cnt_d = CW'(1);
            if (DEPTH == 1) begin
              state_d = HOLD;
            end else if (last_c) begin
              state_d = PAD;
            end else begin
              state_d = FILL;
            end
          end else begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end

      PAD: begin
        write_en_c = 1'b1;
        shift_in_c = '0;
        cnt_d      = cnt_inc_c;
        if (cnt_inc_c == CW'(DEPTH)) begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  assign out_valid = (state_q == HOLD);
  assign beat_cnt  = cnt_q;

  beat_shift_register #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst_n    (~rst),
    .write_en (write_en_c),
    .data_in  (shift_in_c),
    .data_out (out_data)
  );

endmodule

// File: tb/tb_beat_packer_ctrl.sv
// Bench for beat_packer_ctrl: directed and random traffic against a queue-based model.
module tb_beat_packer_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data = '0;
  logic                   in_last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [WIDTH*DEPTH-1:0] out_data;
  logic [CW-1:0]          beat_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: beats of the partial word, and the completed word awaiting acceptance.
  logic [WIDTH-1:0]       part_q[$];
  bit                     held_v  = 0;
  logic [WIDTH*DEPTH-1:0] held_w  = '0;
  bit                     padding = 0;
`ifdef BEAT_PACKER_FLUSH_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  beat_packer_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef BEAT_PACKER_FLUSH_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .beat_cnt  (beat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH*DEPTH-1:0] pack_model();
    logic [WIDTH*DEPTH-1:0] w = '0;
    foreach (part_q[i]) w = (w << WIDTH) | (WIDTH*DEPTH)'(part_q[i]);
    return w;
  endfunction

  // One clock cycle: drive, check at negedge, update model across the posedge.
  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit l);
    bit exp_ir, beat_acc, word_acc;
    int unsigned exp_cnt;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    in_last   = l;
    @(negedge clk);
    exp_ir  = !padding && (!held_v || r);
    exp_cnt = held_v ? DEPTH : part_q.size();
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(held_v));
    chk("beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
    if (held_v) chk("out_data", 32'(out_data), 32'(held_w));
    beat_acc = v && exp_ir;
    word_acc = held_v && r;
    @(posedge clk);
    #1;
    if (word_acc) held_v = 0;
    if (padding) begin
      part_q.push_back('0);
    end else if (beat_acc) begin
      part_q.push_back(d);
      if (LAST_EN && l && part_q.size() < DEPTH) padding = 1;
    end
    if (part_q.size() == DEPTH) begin
      held_w  = pack_model();
      held_v  = 1;
      padding = 0;
      part_q.delete();
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    part_q.delete();
    held_v  = 0;
    padding = 0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    do_reset();

    // Beats 1..4 with out_ready=1: one-cycle word 1234.
    for (int i = 1; i <= 4; i++) step(1, WIDTH'(i), 1, 0);
    chk("t1_word", 32'(out_data), 32'h1234);
    chk("t1_valid", 32'(out_valid), 32'd1);
    step(0, 0, 1, 0);
    chk("t1_cnt_after", 32'(beat_cnt), 32'd0);
    chk("t1_valid_drop", 32'(out_valid), 32'd0);

    // Backpressure: word held, beat 5 stalled then accepted on the bypass.
    for (int i = 1; i <= 4; i++) step(1, WIDTH'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4'h5, 0, 0);
    chk("t2_word_held", 32'(out_data), 32'h1234);
    step(1, 4'h5, 1, 0);
    chk("t2_bypass_cnt", 32'(beat_cnt), 32'd1);
    step(0, 0, 1, 0);
    do_reset();

    // Continuous beats 1..8 at full rate.
    for (int i = 1; i <= 8; i++) step(1, WIDTH'(i), 1, 0);
    chk("t3_word2", 32'(out_data), 32'h5678);
    step(0, 0, 1, 0);

    // Reset discards a partial word.
    step(1, 4'h1, 1, 0);
    step(1, 4'h2, 1, 0);
    do_reset();
    chk("t4_cnt_cleared", 32'(beat_cnt), 32'd0);
    step(1, 4'h9, 1, 0);
    step(1, 4'hA, 1, 0);
    step(1, 4'hB, 1, 0);
    step(1, 4'hC, 1, 0);
    chk("t4_word", 32'(out_data), 32'h9ABC);
    step(0, 0, 1, 0);

`ifdef BEAT_PACKER_FLUSH_EN
    // Short word flushed with zero padding.
    do_reset();
    step(1, 4'h7, 1, 0);
    step(1, 4'h8, 1, 1);
    step(1, 4'hF, 1, 0);
    step(1, 4'hF, 1, 0);
    chk("t5_padded_word", 32'(out_data), 32'h7800);
    chk("t5_valid", 32'(out_valid), 32'd1);
    step(0, 0, 1, 0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), WIDTH'($urandom), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beat_packer_ctrl.md
Name: beat_packer_ctrl

Overview:
- Controller that sequences the team's beat_shift_register: accepts WIDTH-bit beats over a valid/ready handshake, drives the register's write_en, counts DEPTH beats and presents the packed WIDTH*DEPTH word downstream over a second valid/ready handshake.
- Sits between a narrow streaming source and a wide consumer; holds the register stable (no shifting) while a packed word awaits acceptance.

Parameters:
- DEPTH, 4, beats per packed word (>=1)
- WIDTH, 4, bits per beat

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  controller can accept a beat this cycle
- in_data  input  WIDTH  upstream beat
- out_valid  output  1  packed word available
- out_ready  input  1  downstream accepts word
- out_data  output  WIDTH*DEPTH  packed word; bits [WIDTH-1:0] = newest beat, top slice = oldest
- beat_cnt  output  $clog2(DEPTH+1)  beats held in current partial word

Behaviour:
- Reset (async, rst=1): state=FILL, beat_cnt=0, out_valid=0, in_ready=0 while rst asserted and 1 the cycle after release; shift register cleared (sub-module reset is active-low, driven with ~rst).
- Beat accept = in_valid & in_ready; word accept = out_valid & out_ready.
- write_en to the register = beat accept; data_in = in_data, combinational, same cycle.
- FILL: in_ready=1, out_valid=0. Each beat accept increments beat_cnt. The accept bringing beat_cnt to DEPTH -> HOLD next cycle with beat_cnt=DEPTH.
- HOLD: out_valid=1, out_data = register contents, stable; in_ready=out_ready (bypass: a new beat may enter in the same cycle the word leaves).
  - word accept, no beat: -> FILL, beat_cnt=0.
  - word accept + beat accept: beat_cnt=1; -> FILL (DEPTH>1) or stay HOLD (DEPTH==1).
  - no word accept: stay HOLD, in_ready=0, write_en=0, register frozen.
- Latency: first beat of a word to out_valid = DEPTH cycles of accepts, then out_valid rises the next cycle. Sustained throughput 1 beat/cycle with out_ready=1.
- in_valid while in_ready=0: ignored, no shift, beat_cnt unchanged.
- out_ready while out_valid=0: ignored.
- rst mid-word or mid-HOLD: partial or held word discarded, no out_valid pulse.
- beat_cnt never exceeds DEPTH; overflow impossible by construction.

Optional Feature:
- Macro BEAT_PACKER_FLUSH_EN. When defined: extra input in_last (1 bit) and state PAD.
  - A beat accepted with in_last=1 and beat_cnt+1<DEPTH -> PAD.
  - PAD: in_ready=0, write_en=1, data_in=0 each cycle until beat_cnt reaches DEPTH -> HOLD. Real beats end up left-aligned above zero padding.
  - in_last on the DEPTH-th beat -> HOLD directly.
- When undefined: no in_last port and no PAD state; words only complete at DEPTH beats.

Decomposition:
- Package beat_packer_pkg: state enum (FILL, HOLD, PAD), count-width helper function.
- Single sub-module: existing beat_shift_register (same DEPTH/WIDTH), instantiated inside the controller as the datapath.

Test Plan:
- Reset, then beats 1,2,3,4 with out_ready=1 -> out_valid one cycle, out_data=16'h1234, beat_cnt 1,2,3,4,0.
- Beats 1..4 with out_ready=0 for 3 cycles, in_valid held with 5 -> in_ready=0, out_data stays 16'h1234; on out_ready=1 beat 5 accepted same cycle, beat_cnt=1.
- Continuous beats 1..8 with out_ready=1 -> words 16'h1234 then 16'h5678, no dropped beat, 1 beat/cycle.
- rst pulse after beats 1,2 -> beat_cnt=0, out_valid=0; then beats 9,A,B,C -> out_data=16'h9ABC.
- BEAT_PACKER_FLUSH_EN: beats 7,8 with in_last on 8 -> 2 PAD cycles, in_ready=0, out_data=16'h7800.
